// File: rtl/timer_apb_regs.sv
// ---------------------------------------------------------------------------
// timer_apb_regs
//   APB slave and register file for the 8-bit timer. It decodes CPU APB
//   transfers, holds the TDR/TCR/TSR registers, drives the counter core's
//   control inputs and captures the core's overflow/underflow pulses into
//   sticky status flags.
//
//   Register map (byte addresses):
//     0x00 TDR  R/W  load value for the core
//     0x01 TCR  R/W  [7] load, [5] down, [4] enable, [1:0] clock select
//     0x02 TSR  R/W0C  [0] OVF, [1] UDF (write 0 clears, write 1 no effect)
//     0x03 TCNT RO   live count from the core
//
//   Handshake: a transfer is IDLE -> SETUP (one cycle) -> ACCESS. ACCESS holds
//   pready low for WAIT_CYCLES cycles, then pready is high for exactly one
//   cycle; prdata and pslverr are only meaningful in that cycle and a write
//   commits on the clock edge that ends it. Dropping psel during ACCESS before
//   pready aborts the transfer without side effects.
//
// Ports:
//   pclk, presetn        clock, asynchronous active-low reset
//   psel, penable        APB select / access phase
//   pwrite, paddr,pwdata APB write flag, address, write data
//   prdata, pready       read data (valid while pready=1), transfer complete
//   pslverr              error response (valid while pready=1)
//   cnt_in               live counter value from the core
//   ovf_pulse, udf_pulse one-cycle overflow / underflow events from the core
//   tdr_o                load value to the core
//   load_o, dn_o, en_o   TCR[7], TCR[5], TCR[4]
//   cks_o                TCR[1:0] clock divider select
//   fsm_state            debug view of the APB FSM (0 IDLE, 1 SETUP, 2 ACCESS)
// ---------------------------------------------------------------------------
module timer_apb_regs #(
   parameter int WAIT_CYCLES = 0,
   parameter int ADDR_W      = 8
) (
   input  logic              pclk,
   input  logic              presetn,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [ADDR_W-1:0] paddr,
   input  logic [7:0]        pwdata,
   output logic [7:0]        prdata,
   output logic              pready,
   output logic              pslverr,
   input  logic [7:0]        cnt_in,
   input  logic              ovf_pulse,
   input  logic              udf_pulse,
   output logic [7:0]        tdr_o,
   output logic              load_o,
   output logic              dn_o,
   output logic              en_o,
   output logic [1:0]        cks_o,
   output logic [1:0]        fsm_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES);
   // Implemented TCR bits: 7, 5, 4, 1, 0.
   localparam logic [7:0] TCR_MASK  = 8'hB3;

   state_t      state, state_n;
   logic [2:0]  wait_cnt, wait_n;
   logic        ready_c;

   logic [7:0]  tdr, tcr;
   logic [1:0]  tsr;

   logic        addr_err;
   logic        wr_ok;
   logic [7:0]  rd_mux;

   // ---------------- FSM state register ----------------
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state    <= IDLE;
         wait_cnt <= 3'd0;
      end else begin
         state    <= state_n;
         wait_cnt <= wait_n;
      end
   end

   // ---------------- FSM next state / outputs ----------------
   // penable is not required to advance: the slave tracks the phases itself.
   always_comb begin
      state_n = state;
      wait_n  = wait_cnt;
      ready_c = 1'b0;
      case (state)
         IDLE: begin
            if (psel) state_n = SETUP;
         end
         SETUP: begin
            wait_n  = WAIT_LOAD;
            state_n = ACCESS;
         end
         ACCESS: begin
            if (!psel) begin
               state_n = IDLE;                 // abort, nothing commits
            end else if (wait_cnt != 3'd0) begin
               wait_n = wait_cnt - 3'd1;
            end else begin
               ready_c = 1'b1;
               state_n = SETUP;                // psel still high
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // ---------------- decode ----------------
   always_comb begin
      addr_err = 1'b0;
      if (paddr > ADDR_W'(3))                  addr_err = 1'b1;
      else if (pwrite && (paddr == ADDR_W'(3))) addr_err = 1'b1;
   end

   assign wr_ok = ready_c && pwrite && !addr_err;

   always_comb begin
      rd_mux = 8'h00;
      case (paddr)
         ADDR_W'(0): rd_mux = tdr;
         ADDR_W'(1): rd_mux = tcr;
         ADDR_W'(2): rd_mux = {6'd0, tsr};
         ADDR_W'(3): rd_mux = cnt_in;
         default:    rd_mux = 8'h00;
      endcase
   end

   assign pready  = ready_c;
   assign pslverr = ready_c && addr_err;
   assign prdata  = (ready_c && !pwrite && !addr_err) ? rd_mux : 8'h00;

   // ---------------- registers ----------------
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         tdr <= 8'h00;
         tcr <= 8'h00;
      end else if (wr_ok) begin
         if (paddr == ADDR_W'(0)) tdr <= pwdata;
         if (paddr == ADDR_W'(1)) tcr <= pwdata & TCR_MASK;
      end
   end

   // Software clear is applied first, hardware set is OR-ed afterwards so a
   // same-cycle event always survives the clear.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         tsr <= 2'b00;
      end else begin
         if (wr_ok && (paddr == ADDR_W'(2)))
            tsr <= (tsr & pwdata[1:0]) | {udf_pulse, ovf_pulse};
         else
            tsr <= tsr | {udf_pulse, ovf_pulse};
      end
   end

   // ---------------- outputs ----------------
   assign tdr_o     = tdr;
   assign load_o    = tcr[7];
   assign dn_o      = tcr[5];
   assign en_o      = tcr[4];
   assign cks_o     = tcr[1:0];
   assign fsm_state = state;

endmodule

// File: tb/tb_timer_apb_regs.sv
module tb_timer_apb_regs;

  logic       pclk;
  int         n_cmp = 0;
  int         n_err = 0;

  // bus 0: WAIT_CYCLES = 0
  logic       rst0, psel0, pen0, pwr0;
  logic [7:0] paddr0, pwdata0, prdata0, cnt0, tdr0;
  logic       prdy0, perr0, ovf0, udf0, load0, dn0, en0;
  logic [1:0] cks0, st0;

  // bus 3: WAIT_CYCLES = 3
  logic       rst3, psel3, pen3, pwr3;
  logic [7:0] paddr3, pwdata3, prdata3, tdr3;
  logic       prdy3, perr3, load3, dn3, en3;
  logic [1:0] cks3, st3;

  timer_apb_regs #(.WAIT_CYCLES(0), .ADDR_W(8)) dut0 (
    .pclk(pclk), .presetn(rst0), .psel(psel0), .penable(pen0), .pwrite(pwr0),
    .paddr(paddr0), .pwdata(pwdata0), .prdata(prdata0), .pready(prdy0),
    .pslverr(perr0), .cnt_in(cnt0), .ovf_pulse(ovf0), .udf_pulse(udf0),
    .tdr_o(tdr0), .load_o(load0), .dn_o(dn0), .en_o(en0), .cks_o(cks0),
    .fsm_state(st0)
  );

  timer_apb_regs #(.WAIT_CYCLES(3), .ADDR_W(8)) dut3 (
    .pclk(pclk), .presetn(rst3), .psel(psel3), .penable(pen3), .pwrite(pwr3),
    .paddr(paddr3), .pwdata(pwdata3), .prdata(prdata3), .pready(prdy3),
    .pslverr(perr3), .cnt_in(8'h00), .ovf_pulse(1'b0), .udf_pulse(1'b0),
    .tdr_o(tdr3), .load_o(load3), .dn_o(dn3), .en_o(en3), .cks_o(cks3),
    .fsm_state(st3)
  );

  // ---------------- clock / reset ----------------
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input int b, input logic s, input logic e, input logic w,
                       input logic [7:0] a, input logic [7:0] d);
    if (b == 0) begin
      psel0 = s; pen0 = e; pwr0 = w; paddr0 = a; pwdata0 = d;
    end else begin
      psel3 = s; pen3 = e; pwr3 = w; paddr3 = a; pwdata3 = d;
    end
  endtask

  // Full transfer: returns read data / error / cycles from psel rising to
  // pready. hw = {udf,ovf} pulses driven during the pready cycle (bus 0).
  task automatic xfer(input int b, input logic w, input logic [7:0] a,
                      input logic [7:0] d, input logic [1:0] hw,
                      output logic [7:0] rd, output logic er, output int lat);
    logic done;
    logic rdy;
    @(negedge pclk);
    drive(b, 1'b1, 1'b0, w, a, d);
    lat = 0; rd = 8'h00; er = 1'b0; done = 1'b0;
    while (!done && lat < 20) begin
      @(posedge pclk); #1;
      lat++;
      if (b == 0) pen0 = 1'b1; else pen3 = 1'b1;
      rdy = (b == 0) ? prdy0 : prdy3;
      if (rdy) begin
        rd   = (b == 0) ? prdata0 : prdata3;
        er   = (b == 0) ? perr0 : perr3;
        done = 1'b1;
        if (b == 0) begin ovf0 = hw[0]; udf0 = hw[1]; end
      end
    end
    if (!done) begin
      n_cmp++; n_err++;
      $error("FAIL xfer_timeout: observed no pready expected pready within 20 cycles");
    end
    @(posedge pclk); #1;        // commit edge
    ovf0 = 1'b0; udf0 = 1'b0;
    drive(b, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) @(posedge pclk);
    #1;
  endtask

  task automatic pulse(input logic o, input logic u);
    @(negedge pclk);
    ovf0 = o; udf0 = u;
    @(negedge pclk);
    ovf0 = 1'b0; udf0 = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] rd;
    logic       er;
    int         lat;

    rst0 = 1'b0; rst3 = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(3, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    cnt0 = 8'h00; ovf0 = 1'b0; udf0 = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    check("rst_prdata", prdata0, 8'h00);
    check("rst_pready", prdy0, 1'b0);
    check("rst_pslverr", perr0, 1'b0);
    check("rst_ctrl", {tdr0, load0, dn0, en0, cks0}, 13'h0);
    check("rst_state", st0, 2'd0);
    @(negedge pclk);
    rst0 = 1'b1; rst3 = 1'b1;

    // 1: reads after reset
    xfer(0, 1'b0, 8'h00, 8'h00, 2'b00, rd, er, lat);
    check("rd_tdr_rst", {er, rd}, 9'h000);
    check("lat_w0", lat, 2);
    xfer(0, 1'b0, 8'h01, 8'h00, 2'b00, rd, er, lat);
    check("rd_tcr_rst", {er, rd}, 9'h000);
    xfer(0, 1'b0, 8'h02, 8'h00, 2'b00, rd, er, lat);
    check("rd_tsr_rst", {er, rd}, 9'h000);
    xfer(0, 1'b0, 8'h03, 8'h00, 2'b00, rd, er, lat);
    check("rd_tcnt_rst", {er, rd}, 9'h000);

    // 2: TDR / TCR write and read-back
    xfer(0, 1'b1, 8'h00, 8'hA5, 2'b00, rd, er, lat);
    check("wr_tdr_err", er, 1'b0);
    check("tdr_o", tdr0, 8'hA5);
    xfer(0, 1'b1, 8'h01, 8'hFF, 2'b00, rd, er, lat);
    check("ctrl_ff", {load0, dn0, en0, cks0}, 5'b11111);
    xfer(0, 1'b0, 8'h00, 8'h00, 2'b00, rd, er, lat);
    check("rd_tdr", rd, 8'hA5);
    xfer(0, 1'b0, 8'h01, 8'h00, 2'b00, rd, er, lat);
    check("rd_tcr", rd, 8'hB3);

    // TCNT follows cnt_in
    cnt0 = 8'h3C;
    xfer(0, 1'b0, 8'h03, 8'h00, 2'b00, rd, er, lat);
    check("rd_tcnt", rd, 8'h3C);

    // 3: OVF sticky, write-1 no effect, write-0 clears
    pulse(1'b1, 1'b0);
    xfer(0, 1'b0, 8'h02, 8'h00, 2'b00, rd, er, lat);
    check("tsr_ovf", rd, 8'h01);
    xfer(0, 1'b1, 8'h02, 8'hFF, 2'b00, rd, er, lat);
    xfer(0, 1'b0, 8'h02, 8'h00, 2'b00, rd, er, lat);
    check("tsr_w1", rd, 8'h01);
    xfer(0, 1'b1, 8'h02, 8'h00, 2'b00, rd, er, lat);
    xfer(0, 1'b0, 8'h02, 8'h00, 2'b00, rd, er, lat);
    check("tsr_w0", rd, 8'h00);

    // 4: set wins over same-cycle clear
    pulse(1'b0, 1'b1);
    xfer(0, 1'b0, 8'h02, 8'h00, 2'b00, rd, er, lat);
    check("tsr_udf", rd, 8'h02);
    xfer(0, 1'b1, 8'h02, 8'h00, 2'b10, rd, er, lat);
    xfer(0, 1'b0, 8'h02, 8'h00, 2'b00, rd, er, lat);
    check("tsr_set_wins", rd, 8'h02);

    // 5: error responses
    xfer(0, 1'b1, 8'h03, 8'h11, 2'b00, rd, er, lat);
    check("wr_tcnt_err", er, 1'b1);
    xfer(0, 1'b0, 8'h07, 8'h00, 2'b00, rd, er, lat);
    check("rd_07_err", {er, rd}, 9'h100);
    xfer(0, 1'b1, 8'h09, 8'h00, 2'b00, rd, er, lat);
    check("wr_09_err", er, 1'b1);
    xfer(0, 1'b0, 8'h00, 8'h00, 2'b00, rd, er, lat);
    check("tdr_kept", {er, rd}, 9'h0A5);
    xfer(0, 1'b0, 8'h01, 8'h00, 2'b00, rd, er, lat);
    check("tcr_kept", rd, 8'hB3);

    // load then start: TCR=0x80 then 0x10
    xfer(0, 1'b1, 8'h01, 8'h80, 2'b00, rd, er, lat);
    check("tcr_load", {load0, dn0, en0, cks0}, 5'b10000);
    xfer(0, 1'b1, 8'h01, 8'h10, 2'b00, rd, er, lat);
    check("tcr_start", {load0, dn0, en0, cks0}, 5'b00100);
    check("tdr_untouched", tdr0, 8'hA5);

    // 6: WAIT_CYCLES=3 latency and reset mid-ACCESS
    xfer(3, 1'b0, 8'h00, 8'h00, 2'b00, rd, er, lat);
    check("lat_w3", lat, 5);
    check("rd_w3", {er, rd}, 9'h000);
    @(negedge pclk);
    drive(3, 1'b1, 1'b0, 1'b1, 8'h00, 8'h55);
    @(posedge pclk); #1;        // SETUP
    pen3 = 1'b1;
    @(posedge pclk); #1;        // ACCESS, wait 3
    @(posedge pclk); #1;        // wait 2
    check("w3_not_ready", prdy3, 1'b0);
    rst3 = 1'b0;
    #1;
    check("w3_rst_pready", prdy3, 1'b0);
    check("w3_rst_state", st3, 2'd0);
    @(negedge pclk);
    drive(3, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge pclk);
    rst3 = 1'b1;
    check("w3_tdr_o", tdr3, 8'h00);
    xfer(3, 1'b0, 8'h00, 8'h00, 2'b00, rd, er, lat);
    check("w3_rd_tdr", rd, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL global_timeout: observed simulation still running expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/timer_apb_regs.md
Name: timer_apb_regs

Overview:
- APB slave and register file for the 8-bit timer. It sits directly upstream of the counter core.
- Decodes APB transfers from the CPU model and holds the TDR, TCR and TSR registers.
- Drives the counter's load value, load/enable/direction/clock-select controls, and a read-back path for the live count.
- Latches the overflow and underflow pulses coming back from the counter into sticky TSR flags.

Parameters:
- WAIT_CYCLES, default 0: number of wait-state cycles inserted in the ACCESS phase before pready rises. Legal range 0..7.
- ADDR_W, default 8: paddr width.

Ports:
- pclk  in  1  system/APB clock
- presetn  in  1  asynchronous active-low reset
- psel  in  1  APB select
- penable  in  1  APB enable (access phase)
- pwrite  in  1  1 = write, 0 = read
- paddr  in  ADDR_W  register address
- pwdata  in  8  write data
- prdata  out  8  read data, valid while pready=1
- pready  out  1  transfer complete
- pslverr  out  1  transfer error, valid while pready=1
- cnt_in  in  8  live counter value from the core
- ovf_pulse  in  1  one-pclk overflow event (0xFF->0x00 counting up)
- udf_pulse  in  1  one-pclk underflow event (0x00->0xFF counting down)
- tdr_o  out  8  load value to the core
- load_o  out  1  TCR[7]; core loads tdr_o while high
- dn_o  out  1  TCR[5]; 1 = count down, 0 = count up
- en_o  out  1  TCR[4]; count enable
- cks_o  out  2  TCR[1:0]; clk_in = pclk divided by 2, 4, 8, 16 for 00, 01, 10, 11

Behaviour:
- Reset (presetn low, asynchronous, any cycle, including mid-transfer):
  - TDR=0x00, TCR=0x00, TSR=0x00.
  - prdata=0x00, pready=0, pslverr=0.
  - FSM to IDLE; wait counter to 0.
  - All control outputs 0.
- Register map:
  - 0x00 TDR: R/W, 8 bits.
  - 0x01 TCR: R/W, implemented bits [7], [5], [4], [1:0]. Bits [6], [3:2] read 0 and writes to them are ignored.
  - 0x02 TSR: bit0 OVF, bit1 UDF. Bits [7:2] read 0.
  - 0x03 TCNT: read-only, returns cnt_in sampled in the completing cycle.
- FSM states:
  - IDLE: wait for psel=1.
  - SETUP: psel=1, penable=0. Always lasts one cycle; load wait counter = WAIT_CYCLES. Next state ACCESS.
  - ACCESS: psel=1, penable=1.
    - If wait counter != 0: decrement, pready=0.
    - When it reaches 0: pready=1 for exactly one cycle, then go to SETUP if psel is still 1, otherwise IDLE.
  - Completion latency = 2 + WAIT_CYCLES pclk from psel rising (SETUP included).
  - psel dropping during ACCESS before pready: abort to IDLE with no register update.
- Writes commit on the pclk edge ending the pready=1 cycle; outputs reflect the new value on the next cycle.
- Reads: prdata is driven combinationally from the decoded register while pready=1; otherwise prdata=0x00.
- Errors:
  - pslverr=1 together with pready for a write to 0x03 or any access with paddr>0x03.
  - An errored write changes no state. An errored read returns 0x00.
- TSR rules:
  - Writing 0 to a bit clears it; writing 1 has no effect.
  - ovf_pulse sets OVF; udf_pulse sets UDF.
  - A hardware set in the same cycle as a software clear of that bit: the set wins, and the bit reads 1.
  - Flags are sticky regardless of en_o.
- TCR[7] is a stored level, not a self-clearing bit. Software writes 0x80 and then 0x10 to load and start.
- Clearing TCR[4] pauses the core; TDR and TSR are untouched.

Test Plan:
1. After reset, read 0x00, 0x01, 0x02, 0x03 with cnt_in=0x00 -> each returns prdata=0x00, pslverr=0; pready rises on cycle 2 after psel with WAIT_CYCLES=0.
2. Write TDR=0xA5 and TCR=0xFF, then read back -> TDR=0xA5, TCR=0xB3; tdr_o=0xA5, load_o=1, dn_o=1, en_o=1, cks_o=2'b11, all one cycle after pready.
3. Pulse ovf_pulse for one cycle, read TSR -> 0x01. Write TSR=0xFF -> TSR still 0x01. Write 0x00 -> TSR=0x00.
4. Assert udf_pulse in the same cycle as the completing write TSR=0x00 with UDF set -> TSR reads 0x02 (set wins).
5. Write to 0x03 and read from 0x07 -> pslverr=1 with pready on both; register contents unchanged; read data 0x00.
6. With WAIT_CYCLES=3: pready rises 5 cycles after psel. Drop presetn mid-ACCESS of a TDR=0x55 write -> TDR stays 0x00, pready=0 immediately, FSM in IDLE.
